// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared types and default sizing for the sample table writer.
//   state_t     : writer FSM state encoding (IDLE, LOAD, DONE)
//   COUNT_WIDTH : default write-address width
//   MAX_VALUE   : default number of table entries
//   DATA_WIDTH  : default sample width
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int COUNT_WIDTH = 7;
  localparam int MAX_VALUE   = 100;
  localparam int DATA_WIDTH  = 8;

endpackage

// File: rtl/sample_table_writer.sv
// sample_table_writer
// Loads a table of max_value samples from a valid/ready stream into a
// simple write-port memory, one write per accepted sample, latency 1.
//
// Optional build macro: SAMPLE_TABLE_CHECKSUM_EN adds a running checksum
// output of all samples written since the last start.
//
// Ports
//   Clk        : clock, all logic on rising edge
//   Rst        : synchronous active-low reset
//   start      : begin (or restart) a table load, level-sampled
//   abort      : cancel a load, return to idle
//   in_valid   : sample stream valid
//   in_data    : sample stream payload
//   in_ready   : sample accepted this cycle when in_valid is also high
//   wr_en      : memory write strobe
//   wr_address : memory write address
//   wr_data    : memory write data
//   busy       : load in progress
//   done       : full table written since last start
//   checksum   : (macro only) sum of samples written, valid with done
//
// state | meaning
// IDLE  | waiting for start, stream ignored
// LOAD  | accepting samples, writing the table
// DONE  | table complete, waiting for reload start
module sample_table_writer
  import pwm_pkg::*;
#(
  parameter int count_width = COUNT_WIDTH,
  parameter int max_value   = MAX_VALUE,
  parameter int data_width  = DATA_WIDTH
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [data_width-1:0]  in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [count_width-1:0] wr_address,
  output logic [data_width-1:0]  wr_data,
  output logic                   busy,
  output logic                   done
`ifdef SAMPLE_TABLE_CHECKSUM_EN
  ,
  output logic [count_width+data_width-1:0] checksum
`endif
);

  localparam logic [count_width-1:0] last_ptr = count_width'(max_value - 1);

  state_t                 state_q, state_d;
  logic [count_width-1:0] ptr_q, ptr_d;
  logic                   accept;
  logic                   at_last;
  logic                   clear;

  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    at_last  = (ptr_q == last_ptr);
    state_d  = state_q;
    clear    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // abort outranks start so a simultaneous pair lands in IDLE
        if (abort) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (start) begin
          state_d = LOAD;
          clear   = 1'b1;
        end
      end
      LOAD: begin
        // abort masks in_ready so the colliding sample is never written
        in_ready = !abort;
        accept   = in_valid && !abort;
        if (abort) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (accept && at_last) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
      end
    endcase

    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = at_last ? '0 : ptr_q + 1'b1;
    end
  end

  assign busy = (state_q == LOAD);
  assign done = (state_q == DONE);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_en   <= accept;
      if (accept) begin
        wr_address <= ptr_q;
        wr_data    <= in_data;
      end
    end
  end

`ifdef SAMPLE_TABLE_CHECKSUM_EN
  // Accumulates at acceptance so the final sum lands together with done.
  always_ff @(posedge Clk) begin
    if (!Rst || clear) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + (count_width + data_width)'(in_data);
    end
  end
`endif

endmodule

// File: doc/sample_table_writer.md
SAMPLE_TABLE_WRITER -- requirements
Module: sample_table_writer

Interface
REQ-001 SHALL have parameter count_width, default 7, address width of the sample memory.
REQ-002 SHALL have parameter max_value, default 100, number of table entries (1 <= max_value <= 2**count_width).
REQ-003 SHALL have parameter data_width, default 8, sample width.
REQ-004 Clk  input  1  single clock; all logic on posedge Clk.
REQ-005 Rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin a table load, level-sampled.
REQ-007 abort  input  1  cancel load in progress.
REQ-008 in_valid  input  1  sample stream valid.
REQ-009 in_data  input  data_width  sample stream payload.
REQ-010 in_ready  output  1  writer accepts sample this cycle.
REQ-011 wr_en  output  1  memory write strobe.
REQ-012 wr_address  output  count_width  memory write address.
REQ-013 wr_data  output  data_width  memory write data.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  complete table written since last start.

Function
REQ-016 SHALL implement FSM with states IDLE, LOAD, DONE.
REQ-017 IDLE: start=1 -> LOAD, write pointer cleared to 0, done cleared.
REQ-018 LOAD: in_ready=1 combinationally; a sample is accepted when in_valid && in_ready.
REQ-019 Each accepted sample SHALL produce exactly one wr_en pulse on the next cycle with wr_address = pointer at acceptance and wr_data = accepted in_data (latency 1).
REQ-020 Pointer SHALL increment by 1 per accepted sample; on acceptance at pointer == max_value-1 the FSM SHALL go to DONE and the pointer SHALL wrap to 0.
REQ-021 in_valid=0 in LOAD SHALL hold pointer, wr_en=0 next cycle; no timeout.
REQ-022 in_ready SHALL be 0 in IDLE and DONE; in_valid there SHALL be ignored.
REQ-023 busy = 1 exactly in LOAD; done = 1 exactly in DONE.
REQ-024 DONE: start=1 -> LOAD with pointer 0 (reload); otherwise stay in DONE.
REQ-025 start while in LOAD SHALL be ignored.
REQ-026 abort=1 in LOAD SHALL return to IDLE next cycle, pointer 0, done 0; a sample accepted in the same cycle SHALL NOT be accepted (abort wins, in_ready forced 0).
REQ-027 abort in IDLE or DONE SHALL go to IDLE; abort and start together SHALL resolve as abort.
REQ-028 wr_en SHALL never be asserted with wr_address >= max_value.
REQ-029 Pointer arithmetic SHALL be count_width bits, compare against max_value-1 only, no overflow possible.

Reset
REQ-030 Rst=0 at a Clk edge SHALL force IDLE, pointer 0, wr_en 0, wr_address 0, wr_data 0, done 0, busy 0, in_ready 0.
REQ-031 Reset mid-LOAD SHALL discard the partial load; no wr_en in the cycle following reset.

Configuration
REQ-032 Macro SAMPLE_TABLE_CHECKSUM_EN defined: SHALL add output checksum (count_width+data_width bits) = unsigned sum of all samples written since last start, cleared on start, abort and reset, valid when done=1.
REQ-033 Macro undefined: no checksum port, no adder logic; all other behaviour identical.

Structure
REQ-034 Shared package pwm_pkg SHALL hold the FSM state enumeration (IDLE, LOAD, DONE) and default constants COUNT_WIDTH=7, MAX_VALUE=100, DATA_WIDTH=8.
REQ-035 No sub-module; pointer, FSM and write register SHALL be inline in one module.

Verification
REQ-036 Reset, start, 100 samples 0..99 with in_valid continuous -> wr_en 100 consecutive cycles, addresses 0..99, data 0..99, done=1 cycle after last, in_ready=0 thereafter.
REQ-037 in_valid toggled 1,0,1,0 during load -> wr_en only after valid cycles, addresses contiguous, completion after 100th accepted sample.
REQ-038 abort after 40 samples -> IDLE, no further wr_en, done=0; new start rewrites from address 0.
REQ-039 Rst=0 asserted after 60 samples -> all outputs 0 next cycle, no wr_en the following cycle.
REQ-040 start held in DONE -> reload from address 0, done drops to 0 one cycle after start.
REQ-041 With SAMPLE_TABLE_CHECKSUM_EN, samples all 255 (max_value=100) -> checksum=25500 when done=1.
